// File: rtl/lif_pkg.sv
// Shared constants for the leaky integrate-and-fire neuron array.
package lif_pkg;

  localparam int DEF_N_NEURONS    = 3;
  localparam int DEF_IN_W         = 5;
  localparam int DEF_POT_W        = 8;
  localparam int DEF_LEAK_SHIFT   = 2;
  localparam int DEF_REFRAC_TICKS = 2;
  localparam int DEF_W_OUT        = 8;

  // Refractory counters are always 4 bits, enough for up to 15 ticks.
  localparam int REFRAC_W = 4;

  // Width of the saturating output spike counter.
  localparam int COUNT_W  = 8;

endpackage

// File: rtl/lif_neuron_cell.sv
// One leaky integrate-and-fire neuron: membrane potential, leak,
// saturating integration, threshold compare and refractory counter.
module lif_neuron_cell
  import lif_pkg::*;
#(
  parameter int IN_W_CELL    = DEF_IN_W,
  parameter int POT_W        = DEF_POT_W,
  parameter int LEAK_SHIFT   = DEF_LEAK_SHIFT,
  parameter int REFRAC_TICKS = DEF_REFRAC_TICKS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic [IN_W_CELL-1:0] in_current,
  input  logic [POT_W-1:0]     threshold,
  output logic                 spike
);

  localparam logic [REFRAC_W-1:0] REFRAC_INIT = REFRAC_W'(REFRAC_TICKS);

  logic [POT_W-1:0]    pot;
  logic [POT_W-1:0]    next_pot;
  logic [POT_W:0]      sum;
  logic [REFRAC_W-1:0] refrac;
  logic                fire;

  // Candidate potential one bit wider than pot so overflow clamps instead of wrapping.
  always_comb begin
    sum      = {1'b0, pot} - {1'b0, (pot >> LEAK_SHIFT)}
             + {{(POT_W + 1 - IN_W_CELL){1'b0}}, in_current};
    next_pot = sum[POT_W] ? '1 : sum[POT_W-1:0];
    fire     = (next_pot >= threshold);
  end

  // Potential, refractory and spike state only move on a tick; spike is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      pot    <= '0;
      refrac <= '0;
      spike  <= 1'b0;
    end else if (tick) begin
      if (refrac != '0) begin
        refrac <= refrac - REFRAC_W'(1);
        pot    <= '0;
        spike  <= 1'b0;
      end else if (fire) begin
        refrac <= REFRAC_INIT;
        pot    <= '0;
        spike  <= 1'b1;
      end else begin
        pot    <= next_pot;
        spike  <= 1'b0;
      end
    end else begin
      spike <= 1'b0;
    end
  end

endmodule

// File: rtl/lif_neuron_array.sv
// Hidden layer of LIF neurons feeding one output LIF neuron, plus a
// saturating count of output spikes.
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int N_NEURONS    = DEF_N_NEURONS,
  parameter int IN_W         = DEF_IN_W,
  parameter int POT_W        = DEF_POT_W,
  parameter int LEAK_SHIFT   = DEF_LEAK_SHIFT,
  parameter int REFRAC_TICKS = DEF_REFRAC_TICKS,
  parameter int W_OUT        = DEF_W_OUT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tick,
  input  logic [N_NEURONS*IN_W-1:0] in_current,
  input  logic [POT_W-1:0]          threshold,
  input  logic                      cnt_clr,
  output logic [N_NEURONS-1:0]      spike,
  output logic                      spike_output,
  output logic [COUNT_W-1:0]        spike_count
);

  localparam logic [31:0] POT_MAX = 32'((1 << POT_W) - 1);

  logic                 tick_q;
  logic [N_NEURONS-1:0] held_spikes;
  logic [N_NEURONS-1:0] src_spikes;
  logic [3:0]           pop;
  logic [31:0]          weighted;
  logic [POT_W-1:0]     out_in;

  genvar g;
  generate
    for (g = 0; g < N_NEURONS; g++) begin : g_hidden
      lif_neuron_cell #(
        .IN_W_CELL   (IN_W),
        .POT_W       (POT_W),
        .LEAK_SHIFT  (LEAK_SHIFT),
        .REFRAC_TICKS(REFRAC_TICKS)
      ) u_cell (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .in_current(in_current[g*IN_W +: IN_W]),
        .threshold (threshold),
        .spike     (spike[g])
      );
    end
  endgenerate

  // Remember the spikes of the last tick so a gap between ticks does not drop them.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q      <= 1'b0;
      held_spikes <= '0;
    end else begin
      tick_q <= tick;
      if (tick_q) begin
        held_spikes <= spike;
      end
    end
  end

  // Output neuron drive: weighted popcount of the previous tick's hidden spikes, clamped.
  always_comb begin
    src_spikes = tick_q ? spike : held_spikes;
    pop        = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      pop = pop + 4'(src_spikes[i]);
    end
    weighted = 32'(pop) * 32'(W_OUT);
    out_in   = (weighted > POT_MAX) ? '1 : weighted[POT_W-1:0];
  end

  lif_neuron_cell #(
    .IN_W_CELL   (POT_W),
    .POT_W       (POT_W),
    .LEAK_SHIFT  (LEAK_SHIFT),
    .REFRAC_TICKS(REFRAC_TICKS)
  ) u_output (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .in_current(out_in),
    .threshold (threshold),
    .spike     (spike_output)
  );

  // Count visible output pulses; a clear landing on a pulse keeps that pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      spike_count <= '0;
    end else if (cnt_clr) begin
      spike_count <= spike_output ? COUNT_W'(1) : '0;
    end else if (spike_output && (spike_count != '1)) begin
      spike_count <= spike_count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Scoreboard bench for lif_neuron_array: the driver runs a tick-level
// behavioural model and queues expected outputs; a monitor compares them.
module tb_lif_neuron_array;
  import lif_pkg::*;

  localparam int N     = 3;
  localparam int IN_W  = 5;
  localparam int LEAK  = 2;
  localparam int REF   = 2;
  localparam int WOUT  = 8;
  localparam int PMAX  = 255;

  logic            clk = 1'b0;
  logic            reset;
  logic            tick;
  logic            cnt_clr;
  logic [N*IN_W-1:0] in_current;
  logic [7:0]      threshold;
  logic [N-1:0]    spike;
  logic            spike_output;
  logic [7:0]      spike_count;

  logic [N-1:0]    spike2;
  logic            spike_output2;
  logic [7:0]      spike_count2;
  logic [7:0]      threshold2;

  typedef struct {
    logic [N-1:0] spk;
    logic         so;
    logic [7:0]   cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int   m_pot[N+1];
  int   m_ref[N+1];
  int   m_last_pop;
  int   m_cnt;
  bit   m_so;
  bit [N-1:0] m_spk;

  lif_neuron_array dut (
    .clk(clk), .reset(reset), .tick(tick), .in_current(in_current),
    .threshold(threshold), .cnt_clr(cnt_clr), .spike(spike),
    .spike_output(spike_output), .spike_count(spike_count)
  );

  lif_neuron_array #(.LEAK_SHIFT(7)) dut2 (
    .clk(clk), .reset(reset), .tick(tick), .in_current(in_current),
    .threshold(threshold2), .cnt_clr(cnt_clr), .spike(spike2),
    .spike_output(spike_output2), .spike_count(spike_count2)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // One LIF neuron tick straight from the rules: refractory, leak, add, clamp, fire.
  function automatic bit neuron_step(int idx, int cur, int thr);
    int nxt;
    if (m_ref[idx] > 0) begin
      m_ref[idx]--;
      m_pot[idx] = 0;
      return 1'b0;
    end
    nxt = m_pot[idx] - (m_pot[idx] >> LEAK) + cur;
    if (nxt > PMAX) nxt = PMAX;
    if (nxt >= thr) begin
      m_pot[idx] = 0;
      m_ref[idx] = REF;
      return 1'b1;
    end
    m_pot[idx] = nxt;
    return 1'b0;
  endfunction

  function automatic logic [N*IN_W-1:0] all_cur(int v);
    logic [N*IN_W-1:0] r;
    for (int i = 0; i < N; i++) r[i*IN_W +: IN_W] = IN_W'(v);
    return r;
  endfunction

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic applyStimulus(input bit rst, input bit tk, input logic [N*IN_W-1:0] cur,
                               input logic [7:0] thr, input bit clr);
    exp_t e;
    int   oin;
    int   new_pop;
    @(negedge clk);
    reset = rst; tick = tk; in_current = cur; threshold = thr; cnt_clr = clr;
    if (rst) begin
      for (int i = 0; i <= N; i++) begin m_pot[i] = 0; m_ref[i] = 0; end
      m_spk = '0; m_so = 1'b0; m_cnt = 0; m_last_pop = 0;
    end else begin
      if (clr) m_cnt = m_so ? 1 : 0;
      else if (m_so && m_cnt < 255) m_cnt++;
      if (tk) begin
        oin = m_last_pop * WOUT;
        if (oin > PMAX) oin = PMAX;
        m_so = neuron_step(N, oin, int'(thr));
        new_pop = 0;
        for (int i = 0; i < N; i++) begin
          m_spk[i] = neuron_step(i, int'(cur[i*IN_W +: IN_W]), int'(thr));
          new_pop += int'(m_spk[i]);
        end
        m_last_pop = new_pop;
      end else begin
        m_spk = '0;
        m_so  = 1'b0;
      end
    end
    e.spk = m_spk; e.so = m_so; e.cnt = 8'(m_cnt);
    sb_q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Neuron 0 at constant 31: default DUT fires on tick 6, the slow-leak DUT saturates and fires on tick 9.
  task automatic directedTrace(input int n_ticks);
    logic [N*IN_W-1:0] cur;
    cur = '0;
    cur[IN_W-1:0] = IN_W'(31);
    for (int k = 1; k <= n_ticks; k++) begin
      applyStimulus(1'b0, 1'b1, cur, 8'd100, 1'b0);
      settle();
      checkOutput($sformatf("trace_spike0_t%0d", k), int'(spike[0]), (k == 6) ? 1 : 0);
      checkOutput($sformatf("sat_spike0_t%0d", k), int'(spike2[0]), (k == 9) ? 1 : 0);
    end
  endtask

  // Monitor: every edge that has a queued expectation is compared just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checkOutput("spike", int'(spike), int'(e.spk));
        checkOutput("spike_output", int'(spike_output), int'(e.so));
        checkOutput("spike_count", int'(spike_count), int'(e.cnt));
      end
    end
  end

  initial begin
    int guard;
    logic [7:0] thr;
    reset = 1'b1; tick = 1'b0; cnt_clr = 1'b0; in_current = '0;
    threshold = 8'd100; threshold2 = 8'd255;

    applyStimulus(1'b1, 1'b0, '0, 8'd100, 1'b0);
    settle();
    checkOutput("reset_spike", int'(spike), 0);
    checkOutput("reset_count", int'(spike_count), 0);

    for (int k = 0; k < 50; k++) applyStimulus(1'b0, 1'b1, '0, 8'd100, 1'b0);
    settle();
    checkOutput("quiet_count", int'(spike_count), 0);

    applyStimulus(1'b1, 1'b0, '0, 8'd100, 1'b0);
    directedTrace(7);
    applyStimulus(1'b1, 1'b1, all_cur(31), 8'd100, 1'b1);
    settle();
    checkOutput("reset_in_refrac", int'(spike), 0);
    directedTrace(9);

    applyStimulus(1'b1, 1'b0, '0, 8'd100, 1'b0);
    for (int k = 0; k < 30; k++)
      applyStimulus(1'b0, (k % 4) != 3, all_cur(31), 8'd100, 1'b0);

    for (int k = 0; k < 600; k++) begin
      case ($urandom_range(0, 3))
        0:       thr = 8'd0;
        1:       thr = 8'd100;
        default: thr = 8'($urandom);
      endcase
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7,
                    (N*IN_W)'($urandom), thr, $urandom_range(0, 19) == 0);
    end

    applyStimulus(1'b1, 1'b0, '0, 8'd0, 1'b0);
    for (int k = 0; k < 900; k++) applyStimulus(1'b0, 1'b1, all_cur(31), 8'd0, 1'b0);
    settle();
    checkOutput("count_saturated", int'(spike_count), 255);

    guard = 0;
    while (!m_so && guard < 10) begin
      applyStimulus(1'b0, 1'b1, all_cur(31), 8'd0, 1'b0);
      guard++;
    end
    checkOutput("pulse_found", int'(m_so), 1);
    applyStimulus(1'b0, 1'b0, all_cur(31), 8'd0, 1'b1);
    settle();
    checkOutput("clr_with_pulse", int'(spike_count), 1);
    applyStimulus(1'b0, 1'b0, all_cur(31), 8'd0, 1'b1);
    settle();
    checkOutput("clr_alone", int'(spike_count), 0);

    settle();
    settle();
    checkOutput("scoreboard_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lif_neuron_array.md
LIF_NEURON_ARRAY -- requirements
Module: lif_neuron_array

Interface
REQ-001 Parameter N_NEURONS, default 3: number of hidden-layer neurons (1..8).
REQ-002 Parameter IN_W, default 5: input current width per neuron.
REQ-003 Parameter POT_W, default 8: membrane potential width (POT_W > IN_W).
REQ-004 Parameter LEAK_SHIFT, default 2: leak is pot >> LEAK_SHIFT (1..POT_W-1).
REQ-005 Parameter REFRAC_TICKS, default 2: refractory length in ticks (0..15).
REQ-006 Parameter W_OUT, default 8: output-neuron input weight per hidden spike.
REQ-007 clk  in  1  sole clock, all state on rising edge.
REQ-008 reset  in  1  synchronous, active-high; clears all state.
REQ-009 tick  in  1  integration enable; state advances only when high.
REQ-010 in_current  in  N_NEURONS*IN_W  unsigned current, neuron i at bits [i*IN_W +: IN_W].
REQ-011 threshold  in  POT_W  runtime firing threshold, shared by all neurons.
REQ-012 cnt_clr  in  1  clears spike_count.
REQ-013 spike  out  N_NEURONS  registered hidden-layer spike pulses.
REQ-014 spike_output  out  1  registered output-neuron spike pulse.
REQ-015 spike_count  out  8  saturating count of spike_output pulses.

Function
REQ-016 Each neuron SHALL hold pot (POT_W bits) and refrac counter (4 bits).
REQ-017 On tick with refrac > 0: refrac decrements, pot stays 0, no spike, input ignored.
REQ-018 On tick with refrac = 0: next = pot - (pot >> LEAK_SHIFT) + input, computed at POT_W+1 bits, saturated to 2^POT_W-1 (never wraps).
REQ-019 If next >= threshold: spike bit = 1, pot <= 0, refrac <= REFRAC_TICKS; else pot <= next.
REQ-020 threshold = 0 SHALL cause a spike on every non-refractory tick.
REQ-021 Spike outputs SHALL be 1-cycle pulses registered on the tick edge; deasserted on every non-tick cycle.
REQ-022 tick = 0: pot and refrac hold; spike and spike_output are 0.
REQ-023 Output neuron uses the same rules; its input = popcount(registered spike) * W_OUT, saturated to 2^POT_W-1.
REQ-024 Output neuron sees hidden spikes registered on the previous tick, so spike_output lags causing hidden spikes by exactly one tick.
REQ-025 Hidden spikes from the final tick before a tick gap SHALL be held (not lost) until the next tick for output-neuron integration.
REQ-026 spike_count increments on each spike_output pulse; saturates at 255.
REQ-027 cnt_clr with simultaneous spike_output SHALL yield spike_count = 1; cnt_clr alone yields 0.

Reset
REQ-028 reset SHALL override tick and cnt_clr; at the next edge all pot, refrac, spike, spike_output, spike_count, and held spikes are 0.
REQ-029 reset mid-refractory or mid-integration SHALL discard all history; first post-reset tick integrates from pot = 0.

Structure
REQ-030 Package lif_pkg SHALL hold default parameter constants and the refrac counter width (4).
REQ-031 One sub-module, lif_neuron_cell (params IN_W_CELL, POT_W, LEAK_SHIFT, REFRAC_TICKS), SHALL be instantiated N_NEURONS+1 times; the top holds popcount, spike holding, and the counter.
REQ-032 No latches, no combinational path from inputs to outputs.

Verification (defaults, threshold = 100 unless stated)
REQ-033 in_current = 0, 50 ticks -> no spikes, spike_count = 0.
REQ-034 Neuron 0 input 31 constant -> pot 31,55,73,86,96; spike[0] on tick 6; pot 0 for 2 refractory ticks, then integration restarts at 31.
REQ-035 Neuron 0 input 31, threshold = 255, LEAK_SHIFT = 7 -> pot 31,62,93,124,155,185,215,245, then saturates at 255 and spikes on tick 9 (no wrap).
REQ-036 All 3 neurons input 31, threshold 100 -> all spike tick 6; output input 24, spike_output fires one tick after the first hidden spike tick at which cumulative output pot >= 100.
REQ-037 reset asserted during refractory with tick high -> all outputs 0 next edge; post-reset trace matches REQ-034 from tick 1.
REQ-038 Force 256 spike_output pulses -> spike_count holds 255; cnt_clr coincident with a pulse -> 1.
